// File: rtl/systolic_pkg.sv
// rtl/systolic_pkg.sv - shared FSM encoding, default sizes and result-width derivation
package systolic_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam int DEFAULT_SIZE   = 4;
  localparam int DEFAULT_I_BITS = 8;

  // Room for a full-width product plus growth from summing SIZE of them.
  function automatic int o_bits_calc(input int size, input int i_bits);
    return 2 * i_bits + $clog2(size);
  endfunction

endpackage

// File: rtl/systolic_pe.sv
// rtl/systolic_pe.sv - processing element: registered A/B forwarding and MAC accumulator
// SYSTOLIC_SIGNED_EN selects two's-complement operands; otherwise operands are unsigned.
module systolic_pe
  import systolic_pkg::*;
#(
  parameter int I_BITS = DEFAULT_I_BITS,
  parameter int O_BITS = o_bits_calc(DEFAULT_SIZE, DEFAULT_I_BITS)
) (
  input  logic              i_clock,
  input  logic              i_reset_n,
  input  logic              en,
  input  logic              clr,
  input  logic [I_BITS-1:0] a_left,
  input  logic [I_BITS-1:0] b_top,
  output logic [I_BITS-1:0] a_right,
  output logic [I_BITS-1:0] b_bottom,
  output logic [O_BITS-1:0] acc
);
  logic              a_sx, b_sx, p_sx;
  logic [2*I_BITS-1:0] a_ext, b_ext, prod;
  logic [O_BITS-1:0]   prod_ext;

`ifdef SYSTOLIC_SIGNED_EN
  assign a_sx = a_left[I_BITS-1];
  assign b_sx = b_top[I_BITS-1];
  assign p_sx = prod[2*I_BITS-1];
`else
  assign a_sx = 1'b0;
  assign b_sx = 1'b0;
  assign p_sx = 1'b0;
`endif

  // Low 2*I_BITS of the extended product are exact for both signed and unsigned operands.
  assign a_ext    = {{I_BITS{a_sx}}, a_left};
  assign b_ext    = {{I_BITS{b_sx}}, b_top};
  assign prod     = a_ext * b_ext;
  assign prod_ext = {{(O_BITS-2*I_BITS){p_sx}}, prod};

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      a_right  <= '0;
      b_bottom <= '0;
      acc      <= '0;
    end else begin
      if (en) begin
        a_right  <= a_left;
        b_bottom <= b_top;
      end
      if (clr)     acc <= '0;
      else if (en) acc <= acc + prod_ext;
    end
  end

endmodule

// File: rtl/systolic_stream_mm.sv
// rtl/systolic_stream_mm.sv - output-stationary SIZE x SIZE systolic matrix multiplier
// Operands signed when SYSTOLIC_SIGNED_EN is defined (handled in systolic_pe).
module systolic_stream_mm
  import systolic_pkg::*;
#(
  parameter int SIZE   = DEFAULT_SIZE,
  parameter int I_BITS = DEFAULT_I_BITS,
  parameter int O_BITS = o_bits_calc(SIZE, I_BITS)
) (
  input  logic                        i_clock,
  input  logic                        i_reset_n,
  input  logic                        i_valid,
  output logic                        o_ready,
  input  logic [SIZE*I_BITS-1:0]      i_a_col,
  input  logic [SIZE*I_BITS-1:0]      i_b_row,
  output logic                        o_c_valid,
  input  logic                        i_c_ready,
  output logic [SIZE*SIZE*O_BITS-1:0] o_c_full,
  output logic                        o_busy
);
  localparam int CNT_W = $clog2(2 * SIZE);

  state_t                      state;
  logic [CNT_W-1:0]            beat_cnt, drain_cnt;
  logic                        accept, adv, clr;
  logic [I_BITS-1:0]           a_src [SIZE];
  logic [I_BITS-1:0]           b_src [SIZE];
  logic [I_BITS-1:0]           a_h   [SIZE][SIZE+1];
  logic [I_BITS-1:0]           b_v   [SIZE+1][SIZE];
  logic [SIZE*SIZE*O_BITS-1:0] acc_flat;
  logic                        unused_edge;

  assign accept = i_valid && o_ready;
  // The whole array moves only on an accepted beat or a drain step, so stalls insert no bubbles.
  assign adv    = accept || (state == ST_DRAIN);
  assign clr    = (state == ST_DONE) || ((state == ST_IDLE) && !accept);

  always_comb begin
    for (int m = 0; m < SIZE; m++) begin
      a_src[m] = accept ? i_a_col[m*I_BITS +: I_BITS] : '0;
      b_src[m] = accept ? i_b_row[m*I_BITS +: I_BITS] : '0;
    end
  end

  for (genvar i = 0; i < SIZE; i++) begin : g_skew
    if (i == 0) begin : g_direct
      assign a_h[0][0] = a_src[0];
      assign b_v[0][0] = b_src[0];
    end else begin : g_regs
      logic [I_BITS-1:0] sa [i];
      logic [I_BITS-1:0] sb [i];
      always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
          for (int s = 0; s < i; s++) begin
            sa[s] <= '0;
            sb[s] <= '0;
          end
        end else if (adv) begin
          sa[0] <= a_src[i];
          sb[0] <= b_src[i];
          for (int s = 1; s < i; s++) begin
            sa[s] <= sa[s-1];
            sb[s] <= sb[s-1];
          end
        end
      end
      assign a_h[i][0] = sa[i-1];
      assign b_v[0][i] = sb[i-1];
    end
  end

  for (genvar i = 0; i < SIZE; i++) begin : g_row
    for (genvar j = 0; j < SIZE; j++) begin : g_col
      systolic_pe #(
        .I_BITS (I_BITS),
        .O_BITS (O_BITS)
      ) u_pe (
        .i_clock   (i_clock),
        .i_reset_n (i_reset_n),
        .en        (adv),
        .clr       (clr),
        .a_left    (a_h[i][j]),
        .b_top     (b_v[i][j]),
        .a_right   (a_h[i][j+1]),
        .b_bottom  (b_v[i+1][j]),
        .acc       (acc_flat[(i*SIZE+j)*O_BITS +: O_BITS])
      );
    end
  end

  always_comb begin
    unused_edge = 1'b0;
    for (int i = 0; i < SIZE; i++) begin
      unused_edge = unused_edge ^ (^a_h[i][SIZE]) ^ (^b_v[SIZE][i]);
    end
  end

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state     <= ST_IDLE;
      beat_cnt  <= '0;
      drain_cnt <= '0;
      o_ready   <= 1'b0;
      o_c_valid <= 1'b0;
      o_busy    <= 1'b0;
      o_c_full  <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          o_ready <= 1'b1;
          if (accept) begin
            state    <= ST_LOAD;
            beat_cnt <= CNT_W'(1);
            o_busy   <= 1'b1;
          end
        end
        ST_LOAD: begin
          if (accept) begin
            if (beat_cnt == CNT_W'(SIZE - 1)) begin
              state     <= ST_DRAIN;
              drain_cnt <= '0;
              o_ready   <= 1'b0;
            end else begin
              beat_cnt <= beat_cnt + CNT_W'(1);
            end
          end
        end
        ST_DRAIN: begin
          // The last product lands one step before this final edge, so acc_flat is complete here.
          if (drain_cnt == CNT_W'(2 * SIZE - 2)) begin
            state     <= ST_DONE;
            o_c_valid <= 1'b1;
            o_c_full  <= acc_flat;
          end else begin
            drain_cnt <= drain_cnt + CNT_W'(1);
          end
        end
        ST_DONE: begin
          if (i_c_ready) begin
            state     <= ST_IDLE;
            beat_cnt  <= '0;
            o_c_valid <= 1'b0;
            o_busy    <= 1'b0;
            o_ready   <= 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: doc/systolic_stream_mm.md
SYSTOLIC_STREAM_MM -- requirements
Module: systolic_stream_mm

Interface
REQ-001 SHALL have parameter SIZE, default 4: array dimension N (N x N PEs), legal range 2..16.
REQ-002 SHALL have parameter I_BITS, default 8: operand width.
REQ-003 SHALL have parameter O_BITS, default 2*I_BITS+$clog2(SIZE): accumulator/result width.
REQ-004 i_clock  input  1  sole clock; all state on its rising edge.
REQ-005 i_reset_n  input  1  asynchronous, active-low reset.
REQ-006 i_valid  input  1  input beat valid.
REQ-007 o_ready  output  1  block accepts a beat this cycle.
REQ-008 i_a_col  input  SIZE*I_BITS  beat k: element m = A[m][k] at bits [m*I_BITS +: I_BITS].
REQ-009 i_b_row  input  SIZE*I_BITS  beat k: element m = B[k][m] at bits [m*I_BITS +: I_BITS].
REQ-010 o_c_valid  output  1  result matrix valid and stable.
REQ-011 i_c_ready  input  1  consumer takes result.
REQ-012 o_c_full  output  SIZE*SIZE*O_BITS  C[i][j] at bits [(i*SIZE+j)*O_BITS +: O_BITS].
REQ-013 o_busy  output  1  high in LOAD, DRAIN, DONE.

Function
REQ-014 SHALL compute C = A x B as an output-stationary SIZE x SIZE systolic array; A flows right, B flows down.
REQ-015 Row i of A SHALL pass i skew registers and column j of B j skew registers before entering the array.
REQ-016 FSM states SHALL be IDLE, LOAD, DRAIN, DONE.
REQ-017 A beat is accepted on an edge where i_valid && o_ready; o_ready SHALL be high only in IDLE and LOAD.
REQ-018 IDLE: accumulators held at zero; first accepted beat -> LOAD with beat counter = 1.
REQ-019 LOAD: each accepted beat increments the beat counter; accepting beat SIZE-1 (the SIZE-th) -> DRAIN.
REQ-020 LOAD with i_valid low SHALL stall: skew registers, PE pipeline and accumulators hold; no zero bubble is injected.
REQ-021 DRAIN: zeros injected, o_ready low, lasting exactly 2*SIZE-1 cycles via drain counter, then -> DONE.
REQ-022 o_c_valid SHALL rise exactly 2*SIZE-1 edges after the edge accepting the last beat.
REQ-023 DONE: o_c_valid high, o_c_full held stable regardless of i_valid, until an edge with i_c_ready high -> IDLE.
REQ-024 o_c_valid and o_ready SHALL never be high in the same cycle; back-to-back operations have one IDLE cycle minimum.
REQ-025 o_c_full SHALL be registered and updated only on DRAIN->DONE; it holds the previous result otherwise.
REQ-026 Products SHALL be 2*I_BITS wide and extended to O_BITS; accumulation wraps modulo 2^O_BITS with no saturation.

Reset
REQ-027 Reset assertion at any state, including mid-LOAD/DRAIN, SHALL immediately force IDLE and clear counters, skew registers and accumulators.
REQ-028 During reset: o_ready=0, o_c_valid=0, o_busy=0, o_c_full=0.
REQ-029 o_ready SHALL be 1 on the first cycle after reset deassertion.

Configuration
REQ-030 Macro SYSTOLIC_SIGNED_EN defined: operands two's-complement, sign-extended before multiply/accumulate.
REQ-031 Macro undefined: operands unsigned, zero-extended; all other behaviour identical.

Structure
REQ-032 Shared package systolic_pkg SHALL hold the FSM state encoding, default SIZE/I_BITS, and the O_BITS derivation function.
REQ-033 One sub-module, systolic_pe: registered A/B forwarding plus MAC accumulator with clear and enable; top instantiates SIZE*SIZE via generate.

Verification
REQ-034 SIZE=4, unsigned, A=identity, B[k][m]=4k+m+1 -> C equals B; o_c_valid 7 cycles after last beat.
REQ-035 Unsigned, all operands 255 -> every C element 260100 (18 bits, no wrap).
REQ-036 SYSTOLIC_SIGNED_EN, all operands -128 -> every C element 65536; A=-1, B=1 -> every C element -4 (0x3FFFC).
REQ-037 Same operands as REQ-034 with i_valid low 3 cycles between each beat -> identical C; o_ready stays high during gaps.
REQ-038 i_c_ready held low 10 cycles in DONE with random i_valid -> o_c_full unchanged, o_ready low; then pulse -> IDLE next cycle.
REQ-039 Reset asserted after beat 2 of a LOAD -> all outputs 0; following full operation of REQ-035 gives 260100 everywhere.
